lfsr_ctrl: RTL and testbench

LFSR_CTRL -- requirements
Module: lfsr_ctrl

---
 rtl/lfsr_ctrl_pkg.sv | 13 +
 rtl/lfsr_ctrl_if.sv | 23 ++
 rtl/lfsr_ctrl_core.sv | 29 ++
 rtl/lfsr_ctrl.sv | 83 ++++++++
 tb/tb_lfsr_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg -- shared types and constants for the LFSR batch controller.
//   state_t        : controller FSM states
//   CNT_W          : width of the batch length field (0 encodes 256)
//   LFSR_WIDTH_DEF : default LFSR width
//   TAP_A_DEF/B    : default feedback taps (XNOR Fibonacci, period 63 at width 6)
package lfsr_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CNT_W          = 8;
  localparam int LFSR_WIDTH_DEF = 6;
  localparam int TAP_A_DEF      = 5;
  localparam int TAP_B_DEF      = 4;
endpackage

// File: rtl/lfsr_ctrl_if.sv
// lfsr_ctrl_if -- request/stream bundle for lfsr_ctrl.
//   start/count/seed_load/seed : batch request (master -> slave)
//   out_data/out_valid         : word stream (slave -> master)
//   out_ready                  : consumer backpressure (master -> slave)
//   busy/done                  : batch status (slave -> master)
import lfsr_ctrl_pkg::*;

interface lfsr_ctrl_if #(parameter int WIDTH = LFSR_WIDTH_DEF);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (output start, count, seed_load, seed, out_ready,
                  input  out_data, out_valid, busy, done);
  modport slave  (input  start, count, seed_load, seed, out_ready,
                  output out_data, out_valid, busy, done);
endinterface

// File: rtl/lfsr_ctrl_core.sv
// lfsr_core -- XNOR Fibonacci LFSR register.
//   clk, rst_n : clock, async active-low reset (state clears to zero)
//   load       : take load_val this edge (wins over en)
//   load_val   : value to load
//   en         : advance one step this edge
//   q          : current state
// All-ones is the lock-up state of XNOR feedback; zero is a legal state.
module lfsr_core #(
  parameter int WIDTH = 6,
  parameter int TAP_A = 5,
  parameter int TAP_B = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  logic fb;

  assign fb = ~(q[TAP_A] ^ q[TAP_B]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= load_val;
    else if (en)   q <= {q[WIDTH-2:0], fb};
  end
endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl -- emits batches of LFSR words over a valid/ready stream.
//   CLK, RESETN : clock, async active-low reset
//   bus         : lfsr_ctrl_if slave (request, stream, status)
// A start in IDLE captures count (0 = 256) and optionally seeds the LFSR;
// each accepted word advances the LFSR; DONE pulses done for one cycle.
// Optional build macro: LFSR_CTRL_LOCKUP_FIX_EN -- maps an all-ones seed
// to zero and pulls an all-ones state in RUN back to zero.
import lfsr_ctrl_pkg::*;

module lfsr_ctrl #(
  parameter int WIDTH = LFSR_WIDTH_DEF,
  parameter int TAP_A = TAP_A_DEF,
  parameter int TAP_B = TAP_B_DEF
) (
  input  logic          CLK,
  input  logic          RESETN,
  lfsr_ctrl_if.slave    bus
);
  state_t           state, state_nxt;
  logic [CNT_W:0]   remaining, remaining_nxt;  // one extra bit holds 256
  logic [WIDTH-1:0] q;
  logic             start_acc, hs;
  logic             core_load;
  logic [WIDTH-1:0] core_val;

  assign start_acc = (state == S_IDLE) && bus.start;
  assign hs        = (state == S_RUN) && bus.out_ready;

`ifdef LFSR_CTRL_LOCKUP_FIX_EN
  logic             lock_fix;
  logic [WIDTH-1:0] seed_in;
  assign seed_in   = (&bus.seed) ? '0 : bus.seed;
  // Recovery is a load, so it overrides the step even without a handshake.
  assign lock_fix  = (state == S_RUN) && (&q);
  assign core_load = (start_acc && bus.seed_load) || lock_fix;
  assign core_val  = lock_fix ? '0 : seed_in;
`else
  assign core_load = start_acc && bus.seed_load;
  assign core_val  = bus.seed;
`endif

  lfsr_core #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_core (
    .clk      (CLK),
    .rst_n    (RESETN),
    .load     (core_load),
    .load_val (core_val),
    .en       (hs),
    .q        (q)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      S_IDLE: if (bus.start) begin
        remaining_nxt = (bus.count == '0) ? (CNT_W+1)'(1 << CNT_W) : {1'b0, bus.count};
        state_nxt     = S_RUN;
      end
      S_RUN: if (hs) begin
        remaining_nxt = remaining - 1'b1;
        if (remaining == (CNT_W+1)'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decode state directly so reset clears them at once.
  assign bus.out_data  = q;
  assign bus.out_valid = (state == S_RUN);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl -- randomized self-checking bench for lfsr_ctrl.
// Reference is a transaction-level model: an arithmetic LFSR step function
// predicts every offered word; batch length and done/busy timing are
// checked against the requested count.
module tb_lfsr_ctrl;
  import lfsr_ctrl_pkg::*;

  localparam int W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_ctrl_if #(.WIDTH(W)) bus();

  lfsr_ctrl #(.WIDTH(W), .TAP_A(5), .TAP_B(4)) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int mq;         // model LFSR state
  int words[$];   // words accepted in the last batch

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // XNOR of bits 5 and 4 shifted into bit 0.
  function automatic int step(input int q);
    int fb;
    fb = (((q >> 5) & 1) == ((q >> 4) & 1)) ? 1 : 0;
    return ((q << 1) & 63) | fb;
  endfunction

  function automatic int load_fix(input int s);
`ifdef LFSR_CTRL_LOCKUP_FIX_EN
    return (s == 63) ? 0 : s;
`else
    return s;
`endif
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One batch: start, stream with random backpressure, then DONE/IDLE.
  // restart_at >= 0 injects a start with a different count mid-run.
  task automatic run_batch(input int cnt, input bit ld, input int sd,
                           input int stall_first, input int ready_pct,
                           input int restart_at, input int restart_cnt);
    int n, got, cyc;
    bit rdy;
    n = (cnt == 0) ? 256 : cnt;
    words.delete();
    bus.start = 1'b1; bus.count = cnt[7:0]; bus.seed_load = ld;
    bus.seed = sd[W-1:0]; bus.out_ready = 1'b0;
    tick;
    bus.start = 1'b0; bus.seed_load = 1'b0;
    if (ld) mq = load_fix(sd);
    got = 0; cyc = 0;
    while (got < n && cyc < 3000) begin
      rdy = (cyc >= stall_first) && ($urandom_range(99) < ready_pct);
      bus.out_ready = rdy;
      if (cyc == restart_at) begin
        bus.start = 1'b1; bus.count = restart_cnt[7:0];
        bus.seed_load = 1'b1; bus.seed = ~bus.seed;
      end else begin
        bus.start = 1'b0; bus.seed_load = 1'b0;
      end
      @(negedge clk);
      chk("run_valid", bus.out_valid, 1);
      chk("run_data", bus.out_data, mq);
      chk("run_done", bus.done, 0);
      chk("run_busy", bus.busy, 1);
      if (rdy) begin
        words.push_back(int'(bus.out_data));
        mq = step(mq);
        got++;
      end
      tick;
      cyc++;
    end
    if (got < n) chk("timeout", 0, 1);
    bus.out_ready = 1'b0; bus.start = 1'b0; bus.seed_load = 1'b0;
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("done_valid", bus.out_valid, 0);
    chk("done_busy", bus.busy, 1);
    chk("done_data", bus.out_data, mq);
    tick;
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_valid", bus.out_valid, 0);
  endtask

  initial begin
    int n3f, mism, c, s;
    bus.start = 1'b0; bus.count = '0; bus.seed_load = 1'b0;
    bus.seed = '0; bus.out_ready = 1'b0;
    mq = 0;

    // Reset state
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.out_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic 3-word batch from reset state
    run_batch(3, 1'b0, 0, 0, 100, -1, 0);
    chk("t1_len", words.size(), 3);
    chk("t1_w0", words[0], 'h00);
    chk("t1_w1", words[1], 'h01);
    chk("t1_w2", words[2], 'h03);

    // Seeded batch with 4 cycles of backpressure first
    run_batch(2, 1'b1, 'h15, 4, 100, -1, 0);
    chk("t2_w0", words[0], 'h15);
    chk("t2_w1", words[1], step('h15));

    // count=0 -> 256 words; period 63, never all-ones
    run_batch(0, 1'b1, 0, 0, 100, -1, 0);
    chk("t3_len", words.size(), 256);
    n3f = 0; mism = 0;
    foreach (words[i]) begin
      if (words[i] == 63) n3f++;
      if (i >= 63 && words[i] != words[i-63]) mism++;
    end
    chk("t3_no3f", n3f, 0);
    chk("t3_period", mism, 0);
    chk("t3_w62_ne_w0", (words[62] != words[0]), 1);

    // Start while busy is ignored
    run_batch(5, 1'b0, 0, 0, 70, 2, 9);
    chk("t4_len", words.size(), 5);

    // Reset mid-batch: immediate drop, no done pulse, restart from zero
    bus.start = 1'b1; bus.count = 8'd10; bus.seed_load = 1'b1; bus.seed = 6'h2A;
    tick;
    bus.start = 1'b0; bus.seed_load = 1'b0; bus.out_ready = 1'b1;
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_done", bus.done, 0);
    #3 rst_n = 1'b1;
    mq = 0;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done || bus.out_valid) c++;
    end
    chk("mid_rst_quiet", c, 0);
    bus.out_ready = 1'b0;
    tick;
    run_batch(3, 1'b0, 0, 0, 100, -1, 0);
    chk("mid_rst_w0", words[0], 'h00);

    // All-ones seed: lock-up behaviour depends on build
    run_batch(3, 1'b1, 63, 0, 100, -1, 0);
`ifdef LFSR_CTRL_LOCKUP_FIX_EN
    chk("lock_w0", words[0], 'h00);
`else
    chk("lock_w0", words[0], 'h3F);
    chk("lock_w2", words[2], 'h3F);
`endif

    // Random batches
    for (int k = 0; k < 8; k++) begin
      c = $urandom_range(20, 1);
      s = $urandom_range(62);
      run_batch(c, 1'($urandom_range(1)), s, $urandom_range(3),
                $urandom_range(100, 30), $urandom_range(6) - 1, $urandom_range(255));
      chk("rand_len", words.size(), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1);
  end
endmodule
